soc_system_pll_supervisor: RTL and testbench

- Sequences the PLL reset and lock qualification for a PLL instance, running on the PLL reference clock.
- Drives the PLL reset, synchronises and debounces `locked`, and releases N downstream channel resets in staggered index order.
- Detects lock loss, re-arms the PLL with bounded retries, and reports status to the HPS/CSR side.

---
 rtl/soc_system_pll_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_soc_system_pll_supervisor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pll_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, qualifies a synchronised lock, releases channel resets in staggered order, and re-arms on lock loss.
// Optional macro SOC_PLL_SUP_LOSS_FILTER_EN: lock loss in RELEASE/RUN must persist LOSS_FILTER_CYC cycles before acting.
module soc_system_pll_supervisor #(
  parameter int NUM_CH           = 4,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 8,
  parameter int MAX_RETRY        = 3,
  parameter int LOSS_FILTER_CYC  = 4
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked_i,
  input  logic              sw_relock_i,
  output logic              pll_rst_o,
  output logic [NUM_CH-1:0] ch_rst_n_o,
  output logic [2:0]        state_o,
  output logic              lock_ok_o,
  output logic              fail_o,
  output logic [7:0]        relock_cnt_o
);

  localparam int RW  = $clog2(RST_PULSE_CYC) + 1;
  localparam int TW  = $clog2(LOCK_TIMEOUT_CYC) + 1;
  localparam int SW  = $clog2(LOCK_STABLE_CYC) + 1;
  localparam int GW  = $clog2(STAGGER_CYC) + 1;
  localparam int CW  = $clog2(NUM_CH) + 1;
  localparam int RTW = $clog2(MAX_RETRY + 1) + 1;
  localparam int LW  = $clog2(LOSS_FILTER_CYC) + 1;
`ifdef SOC_PLL_SUP_LOSS_FILTER_EN
  localparam int LF_EFF = LOSS_FILTER_CYC;
`else
  localparam int LF_EFF = 1;
`endif

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              lk_meta_q, lk_s_q;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]     stb_cnt_q, stb_cnt_d;
  logic [GW-1:0]     stg_cnt_q, stg_cnt_d;
  logic [CW-1:0]     ch_idx_q, ch_idx_d;
  logic [RTW-1:0]    retry_cnt_q, retry_cnt_d;
  logic [LW-1:0]     loss_cnt_q, loss_cnt_d;
  logic              pll_rst_q, pll_rst_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic              lock_ok_q, lock_ok_d;
  logic              fail_q, fail_d;
  logic [7:0]        relock_q, relock_d;

  logic in_rr, lock_lost, stg_tick, tmo_hit, give_up, entering;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      lk_meta_q   <= 1'b0;
      lk_s_q      <= 1'b0;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      stg_cnt_q   <= '0;
      ch_idx_q    <= '0;
      retry_cnt_q <= '0;
      loss_cnt_q  <= '0;
      pll_rst_q   <= 1'b1;
      ch_rst_q    <= '0;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      lk_meta_q   <= pll_locked_i;
      lk_s_q      <= lk_meta_q;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      stg_cnt_q   <= stg_cnt_d;
      ch_idx_q    <= ch_idx_d;
      retry_cnt_q <= retry_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      pll_rst_q   <= pll_rst_d;
      ch_rst_q    <= ch_rst_d;
      lock_ok_q   <= lock_ok_d;
      fail_q      <= fail_d;
      relock_q    <= relock_d;
    end
  end

  // Loss is acted on once the dropout has lasted LF_EFF synchronised cycles.
  assign in_rr     = (state_q == S_RELEASE) || (state_q == S_RUN);
  assign lock_lost = in_rr && !lk_s_q && (loss_cnt_q == LW'(LF_EFF - 1));
  assign stg_tick  = (state_q == S_RELEASE) && (stg_cnt_q == GW'(STAGGER_CYC - 1));
  assign tmo_hit   = (state_q == S_WAIT_LOCK) && !lk_s_q &&
                     (tmo_cnt_q == TW'(LOCK_TIMEOUT_CYC - 1));
  assign give_up   = (MAX_RETRY != 0) && (retry_cnt_q + RTW'(1) == RTW'(MAX_RETRY));

  always_comb begin
    state_d = state_q;
    if (sw_relock_i) begin
      state_d = S_RESET;
    end else begin
      case (state_q)
        S_RESET: begin
          if (rst_cnt_q == RW'(RST_PULSE_CYC - 1)) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lk_s_q)       state_d = S_STABLE;
          else if (tmo_hit) state_d = give_up ? S_FAIL : S_RESET;
        end
        S_STABLE: begin
          if (!lk_s_q) state_d = S_WAIT_LOCK;
          else if (stb_cnt_q == SW'(LOCK_STABLE_CYC - 1))
            state_d = (NUM_CH == 1) ? S_RUN : S_RELEASE;
        end
        S_RELEASE: begin
          if (lock_lost) state_d = S_RESET;
          else if (stg_tick && (ch_idx_q == CW'(NUM_CH - 1))) state_d = S_RUN;
        end
        S_RUN: begin
          if (lock_lost) state_d = S_RESET;
        end
        S_FAIL: state_d = S_FAIL;
        default: state_d = S_RESET;
      endcase
    end

    // Per-state counters restart on every entry, including a relock re-entering RESET.
    entering  = sw_relock_i || (state_d != state_q);
    rst_cnt_d = (!entering && state_q == S_RESET)     ? rst_cnt_q + RW'(1) : '0;
    tmo_cnt_d = (!entering && state_q == S_WAIT_LOCK) ? tmo_cnt_q + TW'(1) : '0;
    stb_cnt_d = (!entering && state_q == S_STABLE)    ? stb_cnt_q + SW'(1) : '0;
    stg_cnt_d = (!entering && state_q == S_RELEASE && !stg_tick) ? stg_cnt_q + GW'(1) : '0;

    ch_idx_d = '0;
    if (state_d == S_RELEASE) begin
      if (state_q != S_RELEASE) ch_idx_d = CW'(1);
      else if (stg_tick)        ch_idx_d = ch_idx_q + CW'(1);
      else                      ch_idx_d = ch_idx_q;
    end

    retry_cnt_d = retry_cnt_q;
    if (sw_relock_i)                     retry_cnt_d = '0;
    else if (tmo_hit && MAX_RETRY != 0)  retry_cnt_d = retry_cnt_q + RTW'(1);
    else if (state_d == S_RUN)           retry_cnt_d = '0;

    // The filter keeps counting across the RELEASE->RUN hand-off.
    loss_cnt_d = (!sw_relock_i && in_rr && !lk_s_q &&
                  (state_d == S_RELEASE || state_d == S_RUN)) ? loss_cnt_q + LW'(1) : '0;
  end

  always_comb begin
    pll_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
    lock_ok_d = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
    ch_rst_d  = '0;
    if (state_d == S_RUN) begin
      ch_rst_d = '1;
    end else if (state_d == S_RELEASE) begin
      if (state_q != S_RELEASE) ch_rst_d = NUM_CH'(1);
      else if (stg_tick)        ch_rst_d = ch_rst_q | (NUM_CH'(1) << ch_idx_q);
      else                      ch_rst_d = ch_rst_q;
    end
    relock_d = relock_q;
    if (lock_lost && relock_q != 8'hFF) relock_d = relock_q + 8'd1;
  end

  assign pll_rst_o    = pll_rst_q;
  assign ch_rst_n_o   = ch_rst_q;
  assign state_o      = state_q;
  assign lock_ok_o    = lock_ok_q;
  assign fail_o       = fail_q;
  assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_soc_system_pll_supervisor.sv
// Directed bench for soc_system_pll_supervisor: power-up table plus hand-written lock-loss, relock, reset and retry sequences.
module tb_soc_system_pll_supervisor;

  localparam int NUM_CH = 4;
`ifdef SOC_PLL_SUP_LOSS_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic              refclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              locked = 1'b0;
  logic              sw = 1'b0;
  logic              pll_rst_o;
  logic [NUM_CH-1:0] ch_rst_n_o;
  logic [2:0]        state_o;
  logic              lock_ok_o;
  logic              fail_o;
  logic [7:0]        relock_cnt_o;

  int checks = 0;
  int errors = 0;

  soc_system_pll_supervisor #(
    .NUM_CH(4), .RST_PULSE_CYC(4), .LOCK_STABLE_CYC(8), .LOCK_TIMEOUT_CYC(32),
    .STAGGER_CYC(2), .MAX_RETRY(3), .LOSS_FILTER_CYC(4)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked_i(locked), .sw_relock_i(sw),
    .pll_rst_o(pll_rst_o), .ch_rst_n_o(ch_rst_n_o), .state_o(state_o),
    .lock_ok_o(lock_ok_o), .fail_o(fail_o), .relock_cnt_o(relock_cnt_o)
  );

  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         n;
    logic       lk;
    logic       pll;
    logic [3:0] ch;
    logic [2:0] st;
    logic       ok;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic pll, input logic [3:0] ch,
                         input logic [2:0] st, input logic ok, input logic fl,
                         input logic [7:0] rc);
    check($sformatf("%s_pll", name), {31'd0, pll_rst_o}, {31'd0, pll});
    check($sformatf("%s_ch", name), {28'd0, ch_rst_n_o}, {28'd0, ch});
    check($sformatf("%s_st", name), {29'd0, state_o}, {29'd0, st});
    check($sformatf("%s_ok", name), {31'd0, lock_ok_o}, {31'd0, ok});
    check($sformatf("%s_fail", name), {31'd0, fail_o}, {31'd0, fl});
    check($sformatf("%s_rc", name), {24'd0, relock_cnt_o}, {24'd0, rc});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      if (state_o == tgt) break;
      step(1);
    end
    check($sformatf("%s_reached", name), {29'd0, state_o}, {29'd0, tgt});
  endtask

  initial begin
    int   pulses;
    int   hi_cyc;
    logic prev;
    bit   got_fail;

    // Expected outputs after each row's cycles; counted in edges from reset release.
    vecs[0]  = '{3, 1'b0, 1'b1, 4'h0, 3'd0, 1'b0};  // E3: still in RESET
    vecs[1]  = '{1, 1'b0, 1'b0, 4'h0, 3'd1, 1'b0};  // E4: pll reset drops
    vecs[2]  = '{6, 1'b0, 1'b0, 4'h0, 3'd1, 1'b0};  // E10
    vecs[3]  = '{2, 1'b1, 1'b0, 4'h0, 3'd1, 1'b0};  // E12: lock still in synchroniser
    vecs[4]  = '{1, 1'b1, 1'b0, 4'h0, 3'd2, 1'b0};  // E13: STABLE
    vecs[5]  = '{7, 1'b1, 1'b0, 4'h0, 3'd2, 1'b0};  // E20
    vecs[6]  = '{1, 1'b1, 1'b0, 4'h1, 3'd3, 1'b0};  // E21: RELEASE, ch0
    vecs[7]  = '{1, 1'b1, 1'b0, 4'h1, 3'd3, 1'b0};  // E22
    vecs[8]  = '{1, 1'b1, 1'b0, 4'h3, 3'd3, 1'b0};  // E23
    vecs[9]  = '{2, 1'b1, 1'b0, 4'h7, 3'd3, 1'b0};  // E25
    vecs[10] = '{1, 1'b1, 1'b0, 4'h7, 3'd3, 1'b0};  // E26
    vecs[11] = '{1, 1'b1, 1'b0, 4'hF, 3'd4, 1'b1};  // E27: RUN
    vecs[12] = '{5, 1'b1, 1'b0, 4'hF, 3'd4, 1'b1};  // E32

    step(5);
    chk_out("reset", 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      locked = vecs[i].lk;
      step(vecs[i].n);
      chk_out($sformatf("pwr%0d", i), vecs[i].pll, vecs[i].ch, vecs[i].st, vecs[i].ok,
              1'b0, 8'd0);
      $display("power-up row %0d: st=%0d ch=%b pll=%b ok=%b", i, state_o, ch_rst_n_o,
               pll_rst_o, lock_ok_o);
    end

    // Lock loss in RUN: outputs react on edge LAT after the drop.
    locked = 1'b0;
    step(LAT - 1);
    chk_out("loss_pre", 1'b0, 4'hF, 3'd4, 1'b1, 1'b0, 8'd0);
    step(1);
    chk_out("loss", 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 8'd1);
    $display("lock loss: st=%0d ch=%b rc=%0d", state_o, ch_rst_n_o, relock_cnt_o);
    locked = 1'b1;
    wait_state(3'd4, 100, "rerun");
    check("rerun_ch", {28'd0, ch_rst_n_o}, 32'hF);
    check("rerun_rc", {24'd0, relock_cnt_o}, 32'd1);

`ifdef SOC_PLL_SUP_LOSS_FILTER_EN
    step(2);
    locked = 1'b0;
    step(2);
    locked = 1'b1;
    step(8);
    chk_out("short_drop", 1'b0, 4'hF, 3'd4, 1'b1, 1'b0, 8'd1);
    $display("short dropout: st=%0d rc=%0d", state_o, relock_cnt_o);
`endif

    // Software relock in RUN without lock loss.
    step(3);
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    chk_out("sw_run", 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 8'd1);
    $display("sw relock: st=%0d rc=%0d", state_o, relock_cnt_o);

    // One-cycle glitch right after STABLE entry restarts qualification.
    wait_state(3'd2, 50, "stb_entry");
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    check("glitch_e2_st", {29'd0, state_o}, 32'd2);
    step(1);
    check("glitch_e3_st", {29'd0, state_o}, 32'd1);
    step(1);
    check("glitch_e4_st", {29'd0, state_o}, 32'd2);
    step(7);
    check("glitch_e11_st", {29'd0, state_o}, 32'd2);
    check("glitch_e11_ch", {28'd0, ch_rst_n_o}, 32'h0);
    step(1);
    check("glitch_e12_st", {29'd0, state_o}, 32'd3);
    check("glitch_e12_ch", {28'd0, ch_rst_n_o}, 32'h1);
    $display("stable glitch: release at +12 st=%0d ch=%b", state_o, ch_rst_n_o);
    wait_state(3'd4, 50, "glitch_run");

    // Relock coinciding with acted-on lock loss counts once.
    step(2);
    locked = 1'b0;
    step(LAT - 1);
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    chk_out("sw_loss", 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 8'd2);
    step(3);
    check("sw_loss_hold_rc", {24'd0, relock_cnt_o}, 32'd2);
    check("sw_loss_hold_st", {29'd0, state_o}, 32'd0);
    $display("sw+loss: st=%0d rc=%0d", state_o, relock_cnt_o);

    // Asynchronous reset in the middle of RELEASE.
    locked = 1'b1;
    wait_state(3'd3, 80, "rel_entry");
    step(2);
    check("rel_mid_ch", {28'd0, ch_rst_n_o}, 32'h3);
    #4;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 8'd0);
    $display("async reset mid-release: st=%0d ch=%b rc=%0d", state_o, ch_rst_n_o, relock_cnt_o);
    locked = 1'b0;
    step(2);
    rst_n = 1'b1;

    // Lock never arrives: three reset pulses of 4 cycles, then FAIL.
    pulses   = 0;
    hi_cyc   = 0;
    prev     = 1'b0;
    got_fail = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fail_o) begin
        got_fail = 1'b1;
        break;
      end
      if (pll_rst_o && !prev) pulses++;
      if (pll_rst_o) hi_cyc++;
      prev = pll_rst_o;
      step(1);
    end
    check("fail_reached", {31'd0, got_fail}, 32'd1);
    check("pll_pulses", pulses, 32'd3);
    check("pll_high_cycles", hi_cyc, 32'd12);
    chk_out("fail", 1'b1, 4'h0, 3'd5, 1'b0, 1'b1, 8'd0);
    $display("retry exhaustion: pulses=%0d st=%0d fail=%b", pulses, state_o, fail_o);
    locked = 1'b1;
    step(10);
    chk_out("fail_hold", 1'b1, 4'h0, 3'd5, 1'b0, 1'b1, 8'd0);
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    chk_out("fail_exit", 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 8'd0);
    $display("fail exit: st=%0d fail=%b", state_o, fail_o);
    wait_state(3'd4, 100, "recover");
    check("recover_ok", {31'd0, lock_ok_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
